// File: rtl/tb_design_08_driver_if.sv
// rtl/tb_design_08_driver_if.sv - start/result/check method bundle between driver and target
interface tb_design_08_driver_if;
  logic [4:0] variable_1_a;
  logic [4:0] variable_1_b;
  logic       EN_start;
  logic       RDY_start;
  logic [4:0] variable_1_c;
  logic [4:0] result;
  logic       RDY_result;
  logic [4:0] variable_1_d;
  logic       EN_check;
  logic       check;
  logic       RDY_check;

  modport master (
    output variable_1_a, variable_1_b, EN_start, variable_1_c, variable_1_d, EN_check,
    input  RDY_start, result, RDY_result, check, RDY_check
  );

  modport slave (
    input  variable_1_a, variable_1_b, EN_start, variable_1_c, variable_1_d, EN_check,
    output RDY_start, result, RDY_result, check, RDY_check
  );
endinterface

// File: rtl/tb_design_08_driver.sv
// rtl/tb_design_08_driver.sv - LFSR-driven start/result/check transaction driver with watchdog
module tb_design_08_driver (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        go,
  input  logic [7:0]                  num_txn,
  tb_design_08_driver_if.master       bus,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout,
  output logic [7:0]                  pass_count,
  output logic [7:0]                  fail_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_RES = 3'd2,
    CHECK    = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_t;

  state_t     state, state_n;
  logic [9:0] lfsr, lfsr_n;
  logic [4:0] c_q, c_n;
  logic [4:0] d_q, d_n;
  logic [7:0] remaining, remaining_n;
  logic [3:0] wait_cnt, wait_cnt_n;
  logic [7:0] pass_n, fail_n;
  logic       advance;
  logic       in_run;

  // x^10 + x^7 + 1, shifting left with the feedback entering bit 0
  logic [9:0] lfsr_step;
  assign lfsr_step = {lfsr[8:0], lfsr[9] ^ lfsr[6]};

  assign bus.variable_1_a = lfsr[9:5];
  assign bus.variable_1_b = lfsr[4:0];
  assign bus.variable_1_c = c_q;
  assign bus.variable_1_d = d_q;

  assign in_run  = (state == START) || (state == WAIT_RES) || (state == CHECK);
  assign busy    = in_run;
  assign done    = (state == DONE);
  assign timeout = (state == ERR);

  // State and datapath registers; reset wins over every handshake
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      lfsr       <= 10'h3FF;
      c_q        <= 5'd0;
      d_q        <= 5'd0;
      remaining  <= 8'd0;
      wait_cnt   <= 4'd0;
      pass_count <= 8'd0;
      fail_count <= 8'd0;
    end else begin
      state      <= state_n;
      lfsr       <= lfsr_n;
      c_q        <= c_n;
      d_q        <= d_n;
      remaining  <= remaining_n;
      wait_cnt   <= wait_cnt_n;
      pass_count <= pass_n;
      fail_count <= fail_n;
    end
  end

  // Next-state, method enables and watchdog; a stalled run state gives up after 16 cycles
  always_comb begin
    state_n      = state;
    lfsr_n       = lfsr;
    c_n          = c_q;
    d_n          = d_q;
    remaining_n  = remaining;
    wait_cnt_n   = wait_cnt;
    pass_n       = pass_count;
    fail_n       = fail_count;
    advance      = 1'b0;
    bus.EN_start = 1'b0;
    bus.EN_check = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (go) begin
          remaining_n = num_txn;
          pass_n      = 8'd0;
          fail_n      = 8'd0;
          wait_cnt_n  = 4'd0;
          state_n     = (num_txn == 8'd0) ? DONE : START;
        end
      end
      START: begin
        bus.EN_start = bus.RDY_start;
        advance      = bus.RDY_start;
        if (bus.RDY_start) begin
          c_n     = bus.variable_1_a ^ bus.variable_1_b;
          lfsr_n  = lfsr_step;
          state_n = WAIT_RES;
        end
      end
      WAIT_RES: begin
        advance = bus.RDY_result;
        if (bus.RDY_result) begin
          d_n     = bus.result;
          state_n = CHECK;
        end
      end
      CHECK: begin
        bus.EN_check = bus.RDY_check;
        advance      = bus.RDY_check;
        if (bus.RDY_check) begin
          if (bus.check) begin
            pass_n = (pass_count == 8'hFF) ? pass_count : pass_count + 8'd1;
          end else begin
            fail_n = (fail_count == 8'hFF) ? fail_count : fail_count + 8'd1;
          end
          remaining_n = remaining - 8'd1;
          state_n     = (remaining == 8'd1) ? DONE : START;
        end
      end
      ERR: begin
        state_n = ERR;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (in_run) begin
      if (advance) begin
        wait_cnt_n = 4'd0;
      end else if (wait_cnt == 4'd15) begin
        wait_cnt_n = 4'd0;
        state_n    = ERR;
      end else begin
        wait_cnt_n = wait_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_tb_design_08_driver.sv
// tb/tb_tb_design_08_driver.sv - directed self-checking bench for tb_design_08_driver
module tb_tb_design_08_driver;

  logic       CLK;
  logic       RST;
  logic       go;
  logic [7:0] num_txn;
  logic       busy, done, timeout;
  logic [7:0] pass_count, fail_count;

  int checks;
  int failures;
  int start_cnt;
  int chk_cnt;
  logic [4:0] seen_a [0:3];
  logic [4:0] seen_b [0:3];
  logic ended;
  logic en_check_seen;

  tb_design_08_driver_if bus ();

  tb_design_08_driver dut (
    .CLK        (CLK),
    .RST        (RST),
    .go         (go),
    .num_txn    (num_txn),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .pass_count (pass_count),
    .fail_count (fail_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    go  = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic pulse_go(input logic [7:0] n);
    go      = 1'b1;
    num_txn = n;
    tick();
    go      = 1'b0;
  endtask

  // Plays the target side until the run ends; alt selects check pattern 1,0,1,... instead of all 1
  task automatic run_until_end(input int max_cycles, input bit alt);
    start_cnt = 0;
    chk_cnt   = 0;
    ended     = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.EN_start) begin
        if (start_cnt < 4) begin
          seen_a[start_cnt] = bus.variable_1_a;
          seen_b[start_cnt] = bus.variable_1_b;
        end
        start_cnt++;
      end
      if (bus.EN_check) begin
        bus.check = alt ? ((chk_cnt % 2) == 0) : 1'b1;
        chk_cnt++;
      end
      if (done || timeout) begin
        ended = 1'b1;
        break;
      end
      tick();
    end
    check_value("run_ended", {31'd0, ended}, 32'd1);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    RST            = 1'b1;
    go             = 1'b0;
    num_txn        = 8'd0;
    bus.RDY_start  = 1'b1;
    bus.RDY_result = 1'b1;
    bus.RDY_check  = 1'b1;
    bus.result     = 5'h0A;
    bus.check      = 1'b1;
    tick();

    // Reset state
    do_reset();
    check_value("rst_busy",     {31'd0, busy},         32'd0);
    check_value("rst_done",     {31'd0, done},         32'd0);
    check_value("rst_timeout",  {31'd0, timeout},      32'd0);
    check_value("rst_en_start", {31'd0, bus.EN_start}, 32'd0);
    check_value("rst_en_check", {31'd0, bus.EN_check}, 32'd0);
    check_value("rst_a",        {27'd0, bus.variable_1_a}, 32'h1F);
    check_value("rst_b",        {27'd0, bus.variable_1_b}, 32'h1F);
    check_value("rst_c",        {27'd0, bus.variable_1_c}, 32'h00);
    check_value("rst_d",        {27'd0, bus.variable_1_d}, 32'h00);
    check_value("rst_pass",     {24'd0, pass_count},   32'd0);

    // Single transaction stepped cycle by cycle
    pulse_go(8'd1);
    check_value("t1_en_start", {31'd0, bus.EN_start}, 32'd1);
    check_value("t1_busy",     {31'd0, busy},         32'd1);
    check_value("t1_a",        {27'd0, bus.variable_1_a}, 32'h1F);
    check_value("t1_b",        {27'd0, bus.variable_1_b}, 32'h1F);
    tick();
    check_value("t1_wait_en_start", {31'd0, bus.EN_start}, 32'd0);
    check_value("t1_c",        {27'd0, bus.variable_1_c}, 32'h00);
    check_value("t1_b_adv",    {27'd0, bus.variable_1_b}, 32'h1E);
    tick();
    check_value("t1_en_check", {31'd0, bus.EN_check}, 32'd1);
    check_value("t1_d",        {27'd0, bus.variable_1_d}, 32'h0A);
    tick();
    check_value("t1_done",     {31'd0, done},         32'd1);
    check_value("t1_busy_end", {31'd0, busy},         32'd0);
    check_value("t1_pass",     {24'd0, pass_count},   32'd1);
    check_value("t1_fail",     {24'd0, fail_count},   32'd0);

    // Three transactions with alternating check outcome
    do_reset();
    pulse_go(8'd3);
    run_until_end(100, 1'b1);
    check_value("t3_starts", start_cnt, 32'd3);
    check_value("t3_checks", chk_cnt,   32'd3);
    check_value("t3_a0", {27'd0, seen_a[0]}, 32'h1F);
    check_value("t3_b0", {27'd0, seen_b[0]}, 32'h1F);
    check_value("t3_b1", {27'd0, seen_b[1]}, 32'h1E);
    check_value("t3_b2", {27'd0, seen_b[2]}, 32'h1C);
    check_value("t3_b_after", {27'd0, bus.variable_1_b}, 32'h18);
    check_value("t3_c_last",  {27'd0, bus.variable_1_c}, 32'h03);
    check_value("t3_pass", {24'd0, pass_count}, 32'd2);
    check_value("t3_fail", {24'd0, fail_count}, 32'd1);

    // Zero-length run from DONE clears counts and starts nothing
    pulse_go(8'd0);
    check_value("t0_done",     {31'd0, done},         32'd1);
    check_value("t0_busy",     {31'd0, busy},         32'd0);
    check_value("t0_en_start", {31'd0, bus.EN_start}, 32'd0);
    check_value("t0_pass",     {24'd0, pass_count},   32'd0);
    check_value("t0_fail",     {24'd0, fail_count},   32'd0);
    tick();
    check_value("t0_still_done", {31'd0, done},       32'd1);

    // Result never ready: watchdog trips after 16 cycles in WAIT_RES
    do_reset();
    bus.RDY_result = 1'b0;
    pulse_go(8'd1);
    tick();
    en_check_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.EN_check) en_check_seen = 1'b1;
      tick();
    end
    check_value("wd_busy_15",    {31'd0, busy},    32'd1);
    check_value("wd_timeout_15", {31'd0, timeout}, 32'd0);
    tick();
    check_value("wd_timeout",   {31'd0, timeout},      32'd1);
    check_value("wd_busy",      {31'd0, busy},         32'd0);
    check_value("wd_done",      {31'd0, done},         32'd0);
    check_value("wd_no_check",  {31'd0, en_check_seen}, 32'd0);
    bus.RDY_result = 1'b1;
    pulse_go(8'd1);
    tick();
    check_value("wd_go_ignored", {31'd0, timeout},      32'd1);
    check_value("wd_no_start",   {31'd0, bus.EN_start}, 32'd0);
    check_value("wd_no_busy",    {31'd0, busy},         32'd0);

    // Reset in the middle of a run, then restart from a fresh LFSR
    do_reset();
    pulse_go(8'd2);
    tick();
    tick();
    tick();
    bus.RDY_result = 1'b0;
    tick();
    check_value("mr_busy", {31'd0, busy},              32'd1);
    check_value("mr_c",    {27'd0, bus.variable_1_c},  32'h01);
    check_value("mr_d",    {27'd0, bus.variable_1_d},  32'h0A);
    check_value("mr_pass", {24'd0, pass_count},        32'd1);
    RST = 1'b1;
    go  = 1'b1;
    num_txn = 8'd1;
    tick();
    RST = 1'b0;
    go  = 1'b0;
    check_value("mr_rst_busy", {31'd0, busy},             32'd0);
    check_value("mr_rst_done", {31'd0, done},             32'd0);
    check_value("mr_rst_c",    {27'd0, bus.variable_1_c}, 32'h00);
    check_value("mr_rst_d",    {27'd0, bus.variable_1_d}, 32'h00);
    check_value("mr_rst_b",    {27'd0, bus.variable_1_b}, 32'h1F);
    check_value("mr_rst_pass", {24'd0, pass_count},       32'd0);
    bus.RDY_result = 1'b1;
    pulse_go(8'd1);
    run_until_end(100, 1'b0);
    check_value("mr_new_a0", {27'd0, seen_a[0]}, 32'h1F);
    check_value("mr_new_b0", {27'd0, seen_b[0]}, 32'h1F);
    check_value("mr_new_pass", {24'd0, pass_count}, 32'd1);

    // Longest run, then a short one that must start from cleared counts
    do_reset();
    pulse_go(8'd255);
    run_until_end(2000, 1'b0);
    check_value("big_starts", start_cnt, 32'd255);
    check_value("big_pass", {24'd0, pass_count}, 32'd255);
    check_value("big_fail", {24'd0, fail_count}, 32'd0);
    pulse_go(8'd2);
    check_value("second_pass_clr", {24'd0, pass_count}, 32'd0);
    check_value("second_busy",     {31'd0, busy},       32'd1);
    run_until_end(100, 1'b0);
    check_value("second_pass", {24'd0, pass_count}, 32'd2);
    check_value("second_done", {31'd0, done},       32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tb_design_08_driver.md
TB_DESIGN_08_DRIVER -- requirements
Module: tb_design_08_driver

Interface
REQ-001 SHALL expose CLK, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL expose RST, input, 1, reset; synchronous, active-high.
REQ-003 SHALL expose go, input, 1, one-cycle pulse that starts a run; sampled only in IDLE or DONE.
REQ-004 SHALL expose num_txn, input, 8, transaction count, sampled on the accepted go.
REQ-005 SHALL expose variable_1_a and variable_1_b, output, 5 each, start-method arguments.
REQ-006 SHALL expose EN_start, output, 1, start-method enable.
REQ-007 SHALL expose RDY_start, input, 1, start-method ready.
REQ-008 SHALL expose variable_1_c, output, 5, result-method argument.
REQ-009 SHALL expose result, input, 5, result-method return value.
REQ-010 SHALL expose RDY_result, input, 1, result-method ready.
REQ-011 SHALL expose variable_1_d, output, 5, check-method argument.
REQ-012 SHALL expose EN_check, output, 1, check-method enable.
REQ-013 SHALL expose check, input, 1, check-method return, valid in EN_check cycle.
REQ-014 SHALL expose RDY_check, input, 1, check-method ready.
REQ-015 SHALL expose busy, done, timeout, output, 1 each, run status.
REQ-016 SHALL expose pass_count and fail_count, output, 8 each, check tallies.

Function
REQ-017 SHALL implement states IDLE, START, WAIT_RES, CHECK, DONE, ERR.
REQ-018 SHALL hold a 10-bit LFSR (x^10+x^7+1, shift left, feedback into bit 0); variable_1_a = lfsr[9:5], variable_1_b = lfsr[4:0], both driven continuously.
REQ-019 SHALL, on go in IDLE/DONE, load remaining = num_txn, clear both counts, clear done, enter START; if num_txn = 0, enter DONE directly.
REQ-020 SHALL drive EN_start = (state = START) and RDY_start, combinationally; EN_start never asserts while RDY_start = 0.
REQ-021 SHALL, in a cycle with EN_start = 1, capture c = a xor b, advance the LFSR once, enter WAIT_RES.
REQ-022 SHALL drive variable_1_c = captured c at all times.
REQ-023 SHALL, in WAIT_RES with RDY_result = 1, capture d = result and enter CHECK the next cycle.
REQ-024 SHALL drive variable_1_d = captured d; EN_check = (state = CHECK) and RDY_check.
REQ-025 SHALL, in a cycle with EN_check = 1, increment pass_count if check = 1 else fail_count, decrement remaining; enter DONE if remaining reaches 0, else START.
REQ-026 SHALL saturate pass_count and fail_count at 255 (no wrap).
REQ-027 SHALL run a 4-bit wait counter, cleared on each state entry, incremented each cycle spent in START, WAIT_RES or CHECK without the advancing condition; at value 15 with condition still false, enter ERR.
REQ-028 SHALL in ERR assert timeout = 1, busy = 0, done = 0, EN_start = EN_check = 0; leave ERR only by reset.
REQ-029 SHALL drive busy = 1 exactly in START, WAIT_RES, CHECK; done = 1 exactly in DONE.
REQ-030 SHALL ignore go while busy or in ERR.

Reset
REQ-031 SHALL on RST = 1 force IDLE, lfsr = 10'h3FF, c = d = 0, remaining = 0, wait counter = 0, counts = 0, busy = done = timeout = 0, EN_start = EN_check = 0, effective the cycle after RST is sampled, also mid-run.
REQ-032 SHALL give RST priority over go and all handshakes in the same cycle.

Verification
REQ-033 Reset then go, num_txn = 1, RDY_* held 1, check = 1 -> EN_start with a = 5'h1F, b = 5'h1F, c = 0; EN_check one cycle after result sampled; done = 1, pass_count = 1, fail_count = 0.
REQ-034 go, num_txn = 3, check alternating 1,0,1 -> pass_count = 2, fail_count = 1, three EN_start pulses, LFSR advanced three times.
REQ-035 go, num_txn = 0 -> DONE next cycle, no EN_start, counts 0.
REQ-036 RDY_result held 0 after start -> timeout = 1 after 16 WAIT_RES cycles, EN_check never asserts, go ignored until RST.
REQ-037 RST asserted in WAIT_RES -> IDLE, all outputs at reset values next cycle; a new go restarts from lfsr = 10'h3FF.
REQ-038 num_txn = 255 with check always 1, then a second run of 2 -> first run pass_count = 255; second run starts at 0, ends at 2.
